// File: rtl/uart_load_ctrl.sv
// ============================================================================
// Module  : uart_load_ctrl
// Purpose : Frame parser behind the UART receiver. It packs data bytes into
//           16-bit words and writes them into the weight or image buffer.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module uart_load_ctrl #(
    parameter int          ADDR_W    = 10,
    parameter int          MAX_WORDS = 512,
    parameter int          WGT_BASE  = 0,
    parameter int          IMG_BASE  = 512,
    parameter logic [7:0]  CMD_WGT   = 8'hA5,
    parameter logic [7:0]  CMD_IMG   = 8'h5A,
    parameter logic [19:0] TMO_CYC   = 20'd100000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_done,
    input  logic [7:0]        rx_byte,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              mem_sel,
    output logic              busy,
    output logic              load_done,
    output logic              err,
    output logic [1:0]        err_code
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LEN_HI  = 3'd1,
        S_LEN_LO  = 3'd2,
        S_DATA_HI = 3'd3,
        S_DATA_LO = 3'd4,
        S_DONE    = 3'd5,
        S_ERR     = 3'd6
    } state_t;

    state_t            state, state_nxt;
    logic [15:0]       len, len_nxt;
    logic [15:0]       word_idx, word_idx_nxt;
    logic [7:0]        hi_byte, hi_byte_nxt;
    logic [ADDR_W-1:0] base, base_nxt;
    logic [19:0]       timer, timer_nxt;
    logic              mem_we_nxt, mem_sel_nxt, busy_nxt, load_done_nxt, err_nxt;
    logic [ADDR_W-1:0] mem_addr_nxt;
    logic [15:0]       mem_wdata_nxt;
    logic [1:0]        err_code_nxt;
    logic              timed_state, timeout;
    logic [15:0]       len_full;

    assign timed_state = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                         (state == S_DATA_HI) || (state == S_DATA_LO);
    // Timer counts idle cycles since the last consumed byte.
    assign timeout     = timed_state && !rx_done && (timer == TMO_CYC - 20'd1);
    assign len_full    = {len[15:8], rx_byte};

    always_comb begin
        state_nxt     = state;
        len_nxt       = len;
        word_idx_nxt  = word_idx;
        hi_byte_nxt   = hi_byte;
        base_nxt      = base;
        timer_nxt     = '0;
        mem_we_nxt    = 1'b0;
        mem_addr_nxt  = mem_addr;
        mem_wdata_nxt = mem_wdata;
        mem_sel_nxt   = mem_sel;
        load_done_nxt = 1'b0;
        err_nxt       = err;
        err_code_nxt  = err_code;

        if (timed_state && !rx_done)
            timer_nxt = timer + 20'd1;

        if (timeout) begin
            state_nxt    = S_ERR;
            err_nxt      = 1'b1;
            err_code_nxt = 2'b11;
        end else begin
            case (state)
                S_IDLE: begin
                    if (rx_done) begin
                        if (rx_byte == CMD_WGT || rx_byte == CMD_IMG) begin
                            state_nxt    = S_LEN_HI;
                            mem_sel_nxt  = (rx_byte == CMD_IMG);
                            base_nxt     = (rx_byte == CMD_IMG) ? ADDR_W'(IMG_BASE)
                                                                : ADDR_W'(WGT_BASE);
                            word_idx_nxt = '0;
                            err_nxt      = 1'b0;
                            err_code_nxt = 2'b00;
                        end else begin
                            err_nxt      = 1'b1;
                            err_code_nxt = 2'b01;
                        end
                    end
                end
                S_LEN_HI: begin
                    if (rx_done) begin
                        len_nxt   = {rx_byte, 8'h00};
                        state_nxt = S_LEN_LO;
                    end
                end
                S_LEN_LO: begin
                    if (rx_done) begin
                        len_nxt = len_full;
                        if (len_full == 16'd0) begin
                            state_nxt = S_DONE;
                        end else if (len_full > 16'(MAX_WORDS)) begin
                            state_nxt    = S_ERR;
                            err_nxt      = 1'b1;
                            err_code_nxt = 2'b10;
                        end else begin
                            state_nxt = S_DATA_HI;
                        end
                    end
                end
                S_DATA_HI: begin
                    if (rx_done) begin
                        hi_byte_nxt = rx_byte;
                        state_nxt   = S_DATA_LO;
                    end
                end
                S_DATA_LO: begin
                    if (rx_done) begin
                        mem_we_nxt    = 1'b1;
                        mem_wdata_nxt = {hi_byte, rx_byte};
                        mem_addr_nxt  = base + word_idx[ADDR_W-1:0];
                        word_idx_nxt  = word_idx + 16'd1;
                        state_nxt     = (word_idx == len - 16'd1) ? S_DONE : S_DATA_HI;
                    end
                end
                S_DONE: begin
                    load_done_nxt = 1'b1;
                    state_nxt     = S_IDLE;
                end
                S_ERR: begin
                    state_nxt = S_IDLE;
                end
                default: begin
                    state_nxt = S_IDLE;
                end
            endcase
        end

        busy_nxt = (state_nxt != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            len       <= '0;
            word_idx  <= '0;
            hi_byte   <= '0;
            base      <= '0;
            timer     <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_sel   <= 1'b0;
            busy      <= 1'b0;
            load_done <= 1'b0;
            err       <= 1'b0;
            err_code  <= 2'b00;
        end else begin
            state     <= state_nxt;
            len       <= len_nxt;
            word_idx  <= word_idx_nxt;
            hi_byte   <= hi_byte_nxt;
            base      <= base_nxt;
            timer     <= timer_nxt;
            mem_we    <= mem_we_nxt;
            mem_addr  <= mem_addr_nxt;
            mem_wdata <= mem_wdata_nxt;
            mem_sel   <= mem_sel_nxt;
            busy      <= busy_nxt;
            load_done <= load_done_nxt;
            err       <= err_nxt;
            err_code  <= err_code_nxt;
        end
    end

endmodule

`default_nettype wire
